// File: rtl/add_word_sequencer.sv
// Multi-word add/subtract sequencer driving an external WIDTH-bit ripple carry adder.
// Optional whole-result zero flag is built when ADD_SEQ_ZERO_FLAG_EN is defined.
module add_word_sequencer #(
    parameter int WIDTH     = 32,
    parameter int MAX_WORDS = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_first,
    input  logic             in_last,
    input  logic             in_sub,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             err
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q;
    logic             carry_q;
    logic             sub_q;
    logic [IDX_W-1:0] idx_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             out_last_q;
    logic             out_cout_q;
    logic             out_ovf_q;
    logic             err_q;

    logic             start;
    logic             sub_d;
    logic [IDX_W-1:0] idx_d;
    logic             accept;
    logic             overrun;
    logic             sum_is_zero;

    // A word arriving in IDLE always begins a new operation, even without in_first.
    assign start       = (state_q == IDLE) || in_first;
    assign sub_d       = start ? in_sub : sub_q;
    assign idx_d       = start ? '0 : idx_q;
    assign in_ready    = !out_valid_q || out_ready;
    assign accept      = in_valid && in_ready;
    assign overrun     = (idx_d == IDX_W'(MAX_WORDS - 1)) && !in_last;
    assign sum_is_zero = (add_sum == '0);

    assign add_a   = in_a;
    assign add_b   = sub_d ? ~in_b : in_b;
    assign add_cin = start ? in_sub : carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            err_q       <= 1'b0;
        end else if (accept) begin
            carry_q     <= add_cout;
            sub_q       <= sub_d;
            out_valid_q <= 1'b1;
            out_sum_q   <= add_sum;
            out_idx_q   <= idx_d;
            out_last_q  <= in_last;
            out_cout_q  <= in_last && add_cout;
            // Carry into the MSB is recovered from the sum bit; xor with carry-out gives overflow.
            out_ovf_q   <= in_last &&
                           (add_cout ^ (add_sum[WIDTH-1] ^ add_a[WIDTH-1] ^ add_b[WIDTH-1]));
            if (overrun) begin
                err_q   <= 1'b1;
                state_q <= IDLE;
                idx_q   <= '0;
            end else if (in_last) begin
                state_q <= IDLE;
                idx_q   <= '0;
            end else begin
                state_q <= ACTIVE;
                idx_q   <= idx_d + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef ADD_SEQ_ZERO_FLAG_EN
    logic zero_q;
    logic zero_prev;
    logic out_zero_q;

    assign zero_prev = start ? 1'b1 : zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q     <= 1'b0;
            out_zero_q <= 1'b0;
        end else if (accept) begin
            zero_q     <= zero_prev && sum_is_zero;
            out_zero_q <= in_last && zero_prev && sum_is_zero;
        end
    end

    assign out_zero = out_zero_q;
`else
    assign out_zero = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_add_word_sequencer.sv
// Self-checking bench for add_word_sequencer: behavioural adder plus a big-integer
// reference model that predicts every result word, flag, handshake and err.
module tb_add_word_sequencer;

    localparam int W   = 32;
    localparam int MW  = 8;
    localparam int IW  = 3;
    localparam int TOT = W * MW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_first;
    logic          in_last;
    logic          in_sub;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_cin;
    logic [W-1:0]  add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          out_cout;
    logic          out_ovf;
    logic          out_zero;
    logic          err;

    add_word_sequencer #(.WIDTH(W), .MAX_WORDS(MW), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last), .in_sub(in_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_idx(out_idx), .out_last(out_last),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero), .err(err)
    );

    // The external ripple carry adder, modelled behaviourally.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0]  sum;
        logic [IW-1:0] idx;
        logic          last;
        logic          cout;
        logic          ovf;
        logic          zero;
    } exp_t;

    exp_t         expQ[$];
    int           checkCount = 0;
    int           passCount  = 0;
    logic [TOT-1:0] bigA;
    logic [TOT-1:0] bigB;
    int           nWord     = 0;
    bit           inOp      = 0;
    bit           opSub     = 0;
    bit           errExp    = 0;
    bit           outFull   = 0;
    bit           randReady = 0;
    int           stallCycles = 0;

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checkCount++;
        assert (obs === expv) passCount++;
        else begin
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
            $error("[TB] check %s", tag);
        end
    endtask

    // Operands are treated as whole (n+1)-word integers; the word just accepted is a slice of their sum.
    task automatic predict();
        logic [TOT:0] mask;
        logic [TOT:0] one;
        logic [TOT:0] aa;
        logic [TOT:0] bop;
        logic [TOT:0] r;
        exp_t         e;
        int           hi;
        if (!inOp || in_first) begin
            nWord = 0;
            bigA  = '0;
            bigB  = '0;
            opSub = in_sub;
        end
        bigA[nWord*W +: W] = in_a;
        bigB[nWord*W +: W] = in_b;
        one  = 1;
        mask = (one << ((nWord + 1) * W)) - one;
        aa   = {1'b0, bigA} & mask;
        bop  = (opSub ? ~{1'b0, bigB} : {1'b0, bigB}) & mask;
        r    = aa + bop + {{TOT{1'b0}}, opSub};
        hi   = (nWord + 1) * W - 1;
        e.sum  = r[nWord*W +: W];
        e.idx  = IW'(nWord);
        e.last = in_last;
        e.cout = in_last && r[hi+1];
        e.ovf  = in_last && (aa[hi] == bop[hi]) && (r[hi] != aa[hi]);
`ifdef ADD_SEQ_ZERO_FLAG_EN
        e.zero = in_last && ((r & mask) == '0);
`else
        e.zero = 1'b0;
`endif
        expQ.push_back(e);
        if (in_last) begin
            inOp = 0;
        end else if (nWord == MW - 1) begin
            inOp   = 0;
            errExp = 1;
        end else begin
            nWord++;
            inOp = 1;
        end
    endtask

    task automatic tick(output bit acc);
        exp_t e;
        if (stallCycles > 0) begin
            out_ready = 1'b0;
            stallCycles--;
        end else begin
            out_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        #1;
        checkOutput("out_valid", {31'b0, out_valid}, {31'b0, outFull});
        checkOutput("in_ready", {31'b0, in_ready}, {31'b0, (!outFull || out_ready)});
        checkOutput("err", {31'b0, err}, {31'b0, errExp});
        if (outFull && expQ.size() > 0) begin
            e = expQ[0];
            checkOutput("out_sum", out_sum, e.sum);
            checkOutput("out_idx", {29'b0, out_idx}, {29'b0, e.idx});
            checkOutput("out_last", {31'b0, out_last}, {31'b0, e.last});
            checkOutput("out_cout", {31'b0, out_cout}, {31'b0, e.cout});
            checkOutput("out_ovf", {31'b0, out_ovf}, {31'b0, e.ovf});
            checkOutput("out_zero", {31'b0, out_zero}, {31'b0, e.zero});
        end
        acc = in_valid && (!outFull || out_ready);
        if (outFull && out_ready) begin
            void'(expQ.pop_front());
            outFull = 0;
        end
        if (acc) begin
            predict();
            outFull = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit first, input bit last, input bit sub);
        bit acc;
        acc      = 0;
        in_a     = a;
        in_b     = b;
        in_first = first;
        in_last  = last;
        in_sub   = sub;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !acc; k++) tick(acc);
        checkCount++;
        assert (acc) passCount++;
        else begin
            $display("[TB] FAIL accept_timeout observed=%0d expected=1", acc);
            $error("[TB] check accept_timeout");
        end
        in_valid = 1'b0;
    endtask

    task automatic idleTicks(input int n);
        bit acc;
        for (int k = 0; k < n; k++) tick(acc);
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 50 && outFull; k++) tick(acc);
        checkOutput("drained", {31'b0, outFull}, 32'd0);
    endtask

    // Asynchronous reset landing between clock edges; registered outputs must clear at once.
    task automatic doReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_sum", out_sum, 32'd0);
        checkOutput("rst_out_idx", {29'b0, out_idx}, 32'd0);
        checkOutput("rst_out_flags", {28'b0, out_last, out_cout, out_ovf, out_zero}, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        expQ.delete();
        outFull = 0;
        inOp    = 0;
        errExp  = 0;
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] randWord();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int len;
        bit sub;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        #12;
        checkOutput("init_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("init_err", {31'b0, err}, 32'd0);
        checkOutput("init_out_sum", out_sum, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 64-bit add, 64-bit subtract, single-word signed overflow
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1, 0, 0);
        applyStimulus(32'h0000_0000, 32'h0000_0000, 0, 1, 0);
        applyStimulus(32'h0000_0000, 32'h0000_0001, 1, 0, 1);
        applyStimulus(32'h0000_0000, 32'h0000_0000, 0, 1, 1);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1, 1, 0);
        drain();

        // Backpressure: output stalls for 5 cycles in the middle of a 3-word add
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1, 0, 0);
        stallCycles = 5;
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 0, 0, 0);
        applyStimulus(32'h1234_5678, 32'h0000_0001, 0, 1, 0);
        drain();

        // Overrun: nine words with no last; the ninth starts a new operation
        for (int k = 0; k < MW + 1; k++)
            applyStimulus(randWord(), randWord(), (k == 0), 0, 0);
        applyStimulus(32'h0000_0005, 32'h0000_0003, 0, 1, 1);
        applyStimulus(32'h0, 32'h0, 1, 0, 0);
        applyStimulus(32'h0, 32'h0, 0, 1, 0);
        drain();

        // Reset mid-operation clears err; next word without in_first is a fresh start
        applyStimulus(32'hDEAD_BEEF, 32'h1111_1111, 1, 0, 0);
        doReset();
        applyStimulus(32'h0000_0010, 32'h0000_0020, 0, 1, 0);
        drain();

        // Randomized operations with random backpressure, gaps and restarts
        randReady = 1;
        for (int op = 0; op < 40; op++) begin
            len = $urandom_range(1, MW);
            sub = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < len; k++) begin
                applyStimulus(randWord(), randWord(),
                              (k == 0) || ($urandom_range(0, 9) == 0),
                              (k == len - 1), $urandom_range(0, 1) == 1 ? sub : ~sub);
                if ($urandom_range(0, 3) == 0) idleTicks(1);
            end
        end
        randReady = 0;
        drain();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
